uart_word_rx: RTL

Serial receive front end that feeds the core's `rx_data` / `rx_check` path.
- Deserialises an 8N1 UART line, one byte at a time.
- Exposes each received byte.
- Packs every 4 consecutive bytes, little-endian, into a 32-bit word for the program/data loader.
- Holds the word under a valid/ready handshake.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_byte_rx.sv | 148 ++++++++++++++
 rtl/uart_word_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver.
//   rx_state_t     : receiver FSM states
//   BYTES_PER_WORD : bytes packed into one loader word
//   BITS_PER_BYTE  : data bits per UART frame (8N1)
//   next_lane()    : assembly lane index after one more byte (wraps mod 4)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_BYTE  = 8;

    // The lane index is the only counter allowed to wrap: 3 -> 0 ends a word.
    function automatic logic [1:0] next_lane(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: rxd synchroniser plus the bit-timing state machine.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   rxd      in   raw UART line, idle high, asynchronous to clk
//   data     out  shifted byte; valid while byte_stb is high
//   byte_stb out  high for the single cycle a good stop bit is sampled
//   ferr_stb out  high for the single cycle a stop bit is sampled low
// The strobes are decoded purely from flops (state, counter, synchroniser)
// so the word assembler can register the byte, lane, word and flags all on
// the same edge, one clock after the stop sample.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rxd,
    output logic [BITS_PER_BYTE-1:0] data,
    output logic                     byte_stb,
    output logic                     ferr_stb
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0]   sync_r;
    logic                     rxs_s;
    rx_state_t                state_r;
    rx_state_t                state_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_s;
    logic [2:0]               nbit_r;
    logic [2:0]               nbit_s;
    logic [BITS_PER_BYTE-1:0] shift_r;
    logic [BITS_PER_BYTE-1:0] shift_s;
    logic                     byte_stb_s;
    logic                     ferr_stb_s;

    assign rxs_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rxd};
        end
    end

    // FSM, bit-timing counter, data-bit counter and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            nbit_r  <= 3'd0;
            shift_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            nbit_r  <= nbit_s;
            shift_r <= shift_s;
        end
    end

    // Next-state decode: START is checked at half a bit, every later sample lands mid-bit.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        nbit_s     = nbit_r;
        shift_s    = shift_r;
        byte_stb_s = 1'b0;
        ferr_stb_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (!rxs_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_s  = '0;
                    nbit_s = 3'd0;
                    if (!rxs_s) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    shift_s = {rxs_s, shift_r[BITS_PER_BYTE-1:1]};
                    if (nbit_r == 3'd7) begin
                        nbit_s  = 3'd0;
                        state_s = STOP;
                    end else begin
                        nbit_s = nbit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = '0;
                    if (rxs_s) begin
                        byte_stb_s = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        ferr_stb_s = 1'b1;
                        state_s    = WAIT_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not be re-read as a stream of start bits.
                cnt_s = '0;
                if (rxs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                nbit_s  = 3'd0;
            end
        endcase
    end

    assign data     = shift_r;
    assign byte_stb = byte_stb_s;
    assign ferr_stb = ferr_stb_s;

endmodule

// File: rtl/uart_word_rx.sv
// UART receive front end: byte receiver plus 4-byte little-endian word
// assembly with a valid/ready holding register and sticky error flags.
// Ports:
//   clk, reset       system clock / asynchronous active-low reset
//   rxd              UART serial line (idle high)
//   rx_data          last good byte; byte_valid pulses one cycle when it updates
//   word_data        assembled word, byte0 in [7:0]; word_valid while unconsumed
//   word_ready       consumer accepts word_data when word_valid is high
//   byte_idx         bytes already collected toward the next word
//   frame_err        sticky: a stop bit sampled low
//   overrun          sticky: a word completed while the holding register was full
//   clr_err          synchronous clear of both sticky flags (a new error wins)
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    rxd,
    output logic [BITS_PER_BYTE-1:0]                rx_data,
    output logic                                    byte_valid,
    output logic [BYTES_PER_WORD*BITS_PER_BYTE-1:0] word_data,
    output logic                                    word_valid,
    input  logic                                    word_ready,
    output logic [1:0]                              byte_idx,
    output logic                                    frame_err,
    output logic                                    overrun,
    input  logic                                    clr_err
);

    localparam int LANE_W = (BYTES_PER_WORD - 1) * BITS_PER_BYTE;

    logic [BITS_PER_BYTE-1:0]                byte_s;
    logic                                    byte_stb_s;
    logic                                    ferr_stb_s;
    logic                                    complete_s;
    logic                                    load_s;
    logic                                    ovr_s;
    logic [BITS_PER_BYTE-1:0]                rx_data_r;
    logic                                    byte_valid_r;
    logic [LANE_W-1:0]                       lanes_r;
    logic [1:0]                              byte_idx_r;
    logic [BYTES_PER_WORD*BITS_PER_BYTE-1:0] word_data_r;
    logic                                    word_valid_r;
    logic                                    frame_err_r;
    logic                                    overrun_r;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_byte_rx (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .data     (byte_s),
        .byte_stb (byte_stb_s),
        .ferr_stb (ferr_stb_s)
    );

    // The 4th lane is never stored: it goes straight into the word with lanes 0..2.
    assign complete_s = byte_stb_s && (byte_idx_r == 2'd3);
    assign load_s     = complete_s && (!word_valid_r || word_ready);
    assign ovr_s      = complete_s && word_valid_r && !word_ready;

    // Byte output register and its one-cycle strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_r    <= '0;
            byte_valid_r <= 1'b0;
        end else begin
            byte_valid_r <= byte_stb_s;
            if (byte_stb_s) begin
                rx_data_r <= byte_s;
            end
        end
    end

    // Lane assembly; framing errors leave a partial word untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes_r    <= '0;
            byte_idx_r <= 2'd0;
        end else if (byte_stb_s) begin
            case (byte_idx_r)
                2'd0:    lanes_r[7:0]   <= byte_s;
                2'd1:    lanes_r[15:8]  <= byte_s;
                2'd2:    lanes_r[23:16] <= byte_s;
                default: lanes_r        <= lanes_r;
            endcase
            byte_idx_r <= next_lane(byte_idx_r);
        end
    end

    // Holding register: a completion may load in the same cycle the old word is consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_data_r  <= '0;
            word_valid_r <= 1'b0;
        end else if (load_s) begin
            word_data_r  <= {byte_s, lanes_r};
            word_valid_r <= 1'b1;
        end else if (word_valid_r && word_ready) begin
            word_valid_r <= 1'b0;
        end
    end

    // Sticky error flags; a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (ferr_stb_s) begin
                frame_err_r <= 1'b1;
            end else if (clr_err) begin
                frame_err_r <= 1'b0;
            end
            if (ovr_s) begin
                overrun_r <= 1'b1;
            end else if (clr_err) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_r;
    assign byte_valid = byte_valid_r;
    assign word_data  = word_data_r;
    assign word_valid = word_valid_r;
    assign byte_idx   = byte_idx_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;

endmodule
